// File: rtl/quantum_timer_if.sv
// quantum_timer_if: groups the core-side signals of the preemption timer.
// master = core/kernel side driving retire, mode, PC, quantum writes and ack;
// slave  = the quantum_timer itself.
interface quantum_timer_if #(
    parameter int QW  = 16,
    parameter int PCW = 10
);
    logic           retire;
    logic           user_mode;
    logic [PCW-1:0] pc_in;
    logic           quantum_load;
    logic [QW-1:0]  quantum_in;
    logic           ack;
    logic           preempt_req;
    logic [PCW-1:0] saved_pc;
    logic [QW-1:0]  remaining;
    logic [7:0]     expired_count;
    logic           wdog_fault;

    modport master (
        output retire, user_mode, pc_in, quantum_load, quantum_in, ack,
        input  preempt_req, saved_pc, remaining, expired_count, wdog_fault
    );

    modport slave (
        input  retire, user_mode, pc_in, quantum_load, quantum_in, ack,
        output preempt_req, saved_pc, remaining, expired_count, wdog_fault
    );
endinterface

// File: rtl/quantum_timer.sv
// quantum_timer: preemption timer for user-mode processes.
// Counts retired user-mode instructions down from a programmable quantum; on
// expiry it raises preempt_req, latches the interrupted PC and holds the
// request until the kernel acks it.
// Optional feature: define QT_WATCHDOG_EN to build a watchdog that sets a
// sticky wdog_fault when a request stays unacked for WDOG_CYCLES cycles.
// Without it wdog_fault is constant 0 and WDOG_CYCLES does not exist.
module quantum_timer #(
    parameter int QW              = 16,
    parameter int PCW             = 10,
    parameter int DEFAULT_QUANTUM = 100
`ifdef QT_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES     = 1024
`endif
) (
    input  logic           clk,
    input  logic           reset,
    quantum_timer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REQUEST,
        S_KERNEL
    } state_e;

    state_e         state_q, state_d;
    logic [QW-1:0]  count_q, count_d;
    logic [QW-1:0]  quantum_q, quantum_d;
    logic           preempt_q, preempt_d;
    logic [PCW-1:0] saved_pc_q, saved_pc_d;
    logic [7:0]     expired_q, expired_d;
    logic           user_retire;

    assign user_retire = bus.retire & bus.user_mode;

    // Next-state logic for the FSM, down-counter, quantum register and outputs
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block can infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        quantum_d  = quantum_q;
        preempt_d  = preempt_q;
        saved_pc_d = saved_pc_q;
        expired_d  = expired_q;

        // The quantum register accepts writes in every state.
        if (bus.quantum_load) begin
            quantum_d = bus.quantum_in;
        end

        case (state_q)
            S_IDLE: begin
                if (quantum_q != '0 && bus.user_mode) begin
                    state_d = S_COUNT;
                    count_d = quantum_q;
                end
            end

            S_COUNT: begin
                // A load in the same cycle as a retire wins: no decrement.
                if (bus.quantum_load) begin
                    count_d = bus.quantum_in;
                    if (bus.quantum_in == '0) begin
                        state_d = S_IDLE;
                    end
                end else if (user_retire && count_q != '0) begin
                    count_d = count_q - 1'b1;
                    if (count_q == QW'(1)) begin
                        state_d    = S_REQUEST;
                        preempt_d  = 1'b1;
                        saved_pc_d = bus.pc_in;
                        if (expired_q != 8'hFF) begin
                            expired_d = expired_q + 8'd1;
                        end
                    end
                end
            end

            S_REQUEST: begin
                // Retire and quantum loads never disturb a pending request.
                if (bus.ack) begin
                    preempt_d = 1'b0;
                    state_d   = S_KERNEL;
                end
            end

            S_KERNEL: begin
                if (bus.user_mode) begin
                    if (quantum_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_COUNT;
                        count_d = quantum_q;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register all timer state; reset is asynchronous so a pending request drops at once
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            quantum_q  <= QW'(DEFAULT_QUANTUM);
            preempt_q  <= 1'b0;
            saved_pc_q <= '0;
            expired_q  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quantum_q  <= quantum_d;
            preempt_q  <= preempt_d;
            saved_pc_q <= saved_pc_d;
            expired_q  <= expired_d;
        end
    end

    assign bus.preempt_req   = preempt_q;
    assign bus.saved_pc      = saved_pc_q;
    assign bus.remaining     = count_q;
    assign bus.expired_count = expired_q;

`ifdef QT_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES) + 1;

    logic [WW-1:0] wdog_q, wdog_d;
    logic          wdog_fault_q, wdog_fault_d;

    // Watchdog: count cycles spent in REQUEST, fault once the limit is reached
    always_comb begin
        wdog_d       = '0;
        wdog_fault_d = wdog_fault_q;
        if (state_q == S_REQUEST) begin
            if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                wdog_fault_d = 1'b1;
            end
            // Keep counting only while the request stays open; saturate at the limit.
            if (state_d == S_REQUEST) begin
                wdog_d = (wdog_q == WW'(WDOG_CYCLES - 1)) ? wdog_q : wdog_q + 1'b1;
            end
        end
    end

    // Watchdog registers; the fault is sticky until reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q       <= '0;
            wdog_fault_q <= 1'b0;
        end else begin
            wdog_q       <= wdog_d;
            wdog_fault_q <= wdog_fault_d;
        end
    end

    assign bus.wdog_fault = wdog_fault_q;
`else
    assign bus.wdog_fault = 1'b0;
`endif

endmodule

// File: tb/tb_quantum_timer.sv
// tb_quantum_timer: directed self-checking bench for quantum_timer.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_quantum_timer;

    localparam int QW  = 16;
    localparam int PCW = 10;
`ifdef QT_WATCHDOG_EN
    localparam int WDOG = 16;
`endif

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;

    quantum_timer_if #(.QW(QW), .PCW(PCW)) bus ();

    quantum_timer #(
        .QW(QW),
        .PCW(PCW),
        .DEFAULT_QUANTUM(100)
`ifdef QT_WATCHDOG_EN
        ,
        .WDOG_CYCLES(WDOG)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Safety net so the run always ends even if the bench itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset            = 1'b1;
        bus.retire       = 1'b0;
        bus.user_mode    = 1'b0;
        bus.pc_in        = '0;
        bus.quantum_load = 1'b0;
        bus.quantum_in   = '0;
        bus.ack          = 1'b0;

        // ---- reset values
        step(2);
        check("rst_preempt",  32'(bus.preempt_req),   0);
        check("rst_remain",   32'(bus.remaining),     0);
        check("rst_saved",    32'(bus.saved_pc),      0);
        check("rst_expired",  32'(bus.expired_count), 0);
        check("rst_wdog",     32'(bus.wdog_fault),    0);

        // ---- 1: default quantum 100, retire held
        reset         = 1'b0;
        bus.user_mode = 1'b1;
        bus.retire    = 1'b1;
        step(1);
        check("t1_load100", 32'(bus.remaining), 100);
        for (int i = 1; i <= 99; i++) begin
            bus.pc_in = PCW'(i);
            step(1);
            check("t1_countdown", 32'(bus.remaining), 32'(100 - i));
        end
        check("t1_no_early_req", 32'(bus.preempt_req), 0);
        bus.pc_in = 10'h2A5;
        step(1);
        check("t1_preempt",  32'(bus.preempt_req),   1);
        check("t1_remain0",  32'(bus.remaining),     0);
        check("t1_saved_pc", 32'(bus.saved_pc),      32'h2A5);
        check("t1_expired",  32'(bus.expired_count), 1);

        // ---- 2: request holds, ack -> KERNEL, resume on user_mode
        bus.pc_in = 10'h001;
        step(2);
        check("t2_req_held",  32'(bus.preempt_req), 1);
        check("t2_no_retire", 32'(bus.remaining),   0);
        check("t2_saved_hold", 32'(bus.saved_pc),   32'h2A5);
        bus.ack       = 1'b1;
        bus.user_mode = 1'b0;
        step(1);
        check("t2_ack_drop", 32'(bus.preempt_req), 0);
        bus.ack = 1'b0;
        step(5);
        check("t2_kernel_wait_req", 32'(bus.preempt_req), 0);
        check("t2_kernel_wait_cnt", 32'(bus.remaining),   0);
        bus.user_mode = 1'b1;
        step(1);
        check("t2_reload", 32'(bus.remaining), 100);
        step(1);
        check("t2_resume", 32'(bus.remaining), 99);

        // ---- 3: load beats retire, short quantum, then quantum 0 -> IDLE
        bus.quantum_load = 1'b1;
        bus.quantum_in   = 16'd3;
        step(1);
        check("t3_load_prio", 32'(bus.remaining), 3);
        bus.quantum_load = 1'b0;
        step(1);
        check("t3_cnt2", 32'(bus.remaining), 2);
        step(1);
        check("t3_cnt1", 32'(bus.remaining), 1);
        bus.pc_in = 10'h155;
        step(1);
        check("t3_preempt", 32'(bus.preempt_req),   1);
        check("t3_saved",   32'(bus.saved_pc),      32'h155);
        check("t3_expired", 32'(bus.expired_count), 2);
        bus.quantum_load = 1'b1;
        bus.quantum_in   = 16'd0;
        step(1);
        check("t3_load_keeps_req", 32'(bus.preempt_req), 1);
        bus.quantum_load = 1'b0;
        bus.ack          = 1'b1;
        step(1);
        check("t3_ack", 32'(bus.preempt_req), 0);
        bus.ack = 1'b0;
        step(20);
        check("t3_idle_no_req", 32'(bus.preempt_req),   0);
        check("t3_idle_cnt",    32'(bus.remaining),     0);
        check("t3_idle_exp",    32'(bus.expired_count), 2);

        // ---- 4: pause on kernel mode, ack outside REQUEST ignored
        bus.quantum_load = 1'b1;
        bus.quantum_in   = 16'd20;
        step(1);
        check("t4_idle_old_q", 32'(bus.remaining), 0);
        bus.quantum_load = 1'b0;
        step(1);
        check("t4_start", 32'(bus.remaining), 20);
        step(1);
        check("t4_dec", 32'(bus.remaining), 19);
        bus.user_mode = 1'b0;
        bus.ack       = 1'b1;
        step(50);
        check("t4_paused",     32'(bus.remaining),   19);
        check("t4_paused_req", 32'(bus.preempt_req), 0);
        bus.user_mode = 1'b1;
        step(1);
        check("t4_resume",      32'(bus.remaining),   18);
        check("t4_ack_ignored", 32'(bus.preempt_req), 0);
        bus.ack = 1'b0;

        // ---- 5: saturate expired_count with quantum 1
        bus.quantum_load = 1'b1;
        bus.quantum_in   = 16'd1;
        step(1);
        check("t5_q1", 32'(bus.remaining), 1);
        bus.quantum_load = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            check("t5_req", 32'(bus.preempt_req), 1);
            check("t5_sat", 32'(bus.expired_count), (3 + i > 255) ? 255 : 32'(3 + i));
            bus.ack = 1'b1;
            step(1);
            bus.ack = 1'b0;
            step(1);
        end
        bus.pc_in = 10'h3FF;
        step(1);
        check("t5_last_req", 32'(bus.preempt_req),   1);
        check("t5_sat_hold", 32'(bus.expired_count), 255);
        check("t5_saved",    32'(bus.saved_pc),      32'h3FF);
`ifndef QT_WATCHDOG_EN
        step(20);
        check("t5_wdog_tied0", 32'(bus.wdog_fault),  0);
        check("t5_req_stays",  32'(bus.preempt_req), 1);
`endif
        // Asynchronous reset between edges.
        #2;
        reset = 1'b1;
        #1;
        check("t5_async_req",  32'(bus.preempt_req),   0);
        check("t5_async_cnt",  32'(bus.remaining),     0);
        check("t5_async_pc",   32'(bus.saved_pc),      0);
        check("t5_async_exp",  32'(bus.expired_count), 0);
        check("t5_async_wdog", 32'(bus.wdog_fault),    0);
        #1;
        reset = 1'b0;
        step(1);
        check("t5_default_q", 32'(bus.remaining), 100);

`ifdef QT_WATCHDOG_EN
        // ---- 6: watchdog on an unacked request
        bus.quantum_load = 1'b1;
        bus.quantum_in   = 16'd2;
        step(1);
        check("t6_q2", 32'(bus.remaining), 2);
        bus.quantum_load = 1'b0;
        step(1);
        check("t6_cnt1", 32'(bus.remaining), 1);
        step(1);
        check("t6_req", 32'(bus.preempt_req), 1);
        step(15);
        check("t6_wdog_before", 32'(bus.wdog_fault), 0);
        step(1);
        check("t6_wdog_fault", 32'(bus.wdog_fault),  1);
        check("t6_req_held",   32'(bus.preempt_req), 1);
        bus.ack = 1'b1;
        step(1);
        check("t6_ack_req",   32'(bus.preempt_req), 0);
        check("t6_wdog_stky", 32'(bus.wdog_fault),  1);
        bus.ack = 1'b0;
        step(3);
        check("t6_wdog_still", 32'(bus.wdog_fault), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
